pipe_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It combines hazard requests from IF, ID, EX and MEM into per-register stall and flush controls for pc_reg, if_id, id_ex, ex_mem and mem_wb. It also owns the redirect of the PC on a taken branch or jump. A small FSM holds a branch resolved under a memory stall, and discards an in-flight wrong-path instruction fetch. It keeps saturating stall and flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 41 ++++
 rtl/pipe_ctrl_sat_counter.sv | 20 ++
 rtl/pipe_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned ADDR_LEN = 32;
  localparam logic [ADDR_LEN-1:0] ZERO_WORD = '0;

  // Sequencer states
  typedef enum logic [1:0] {
    PC_RUN       = 2'd0,
    PC_JUMP_PEND = 2'd1,
    PC_DISCARD   = 2'd2
  } pc_state_e;

  // Per-register pipeline control bundle
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic mem_wb_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic if_discard;
    logic pc_jump;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_IDLE = '0;

  // Frozen pipeline: every register holds, nothing is flushed
  function automatic pipe_ctrl_t ctrl_freeze();
    pipe_ctrl_t c;
    c              = CTRL_IDLE;
    c.pc_stall     = 1'b1;
    c.if_id_stall  = 1'b1;
    c.id_ex_stall  = 1'b1;
    c.ex_mem_stall = 1'b1;
    c.mem_wb_stall = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count enabled increments, stopping at the maximum value
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline, including PC redirect
// handling and stall/redirect performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_stall_req,
  input  logic              id_stall_req,
  input  logic              mem_stall_req,
  input  logic              ex_jump,
  input  logic [ADDR_W-1:0] ex_jump_target,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_stall,
  output logic              ex_mem_stall,
  output logic              mem_wb_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              if_discard,
  output logic              pc_jump,
  output logic [ADDR_W-1:0] pc_target,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  pc_state_e         r_state;
  logic [ADDR_W-1:0] r_target;

  pipe_ctrl_t        w_ctrl;
  logic [ADDR_W-1:0] w_target;
  logic              w_redirect;
  logic              w_active;
  logic              w_stall_inc;
  logic              w_flush_inc;

  assign w_active = !rst && rdy;

  // A redirect fires when MEM is not stalled and either EX just resolved a
  // jump in RUN, or a jump was parked while MEM was busy.
  assign w_redirect = !mem_stall_req &&
                      (((r_state == PC_RUN) && ex_jump) || (r_state == PC_JUMP_PEND));

  // Control outputs from current state and requests, highest priority first
  always_comb begin
    w_ctrl   = CTRL_IDLE;
    w_target = '0;
    if (rst) begin
      w_ctrl = CTRL_IDLE;
    end else if (!rdy) begin
      w_ctrl = ctrl_freeze();
    end else if (mem_stall_req) begin
      // MEM emits a bubble into mem_wb while everything upstream holds;
      // a fetch already being discarded keeps being discarded.
      w_ctrl              = ctrl_freeze();
      w_ctrl.mem_wb_stall = 1'b0;
      w_ctrl.if_discard   = (r_state == PC_DISCARD);
    end else if (w_redirect) begin
      w_ctrl.pc_jump     = 1'b1;
      w_ctrl.if_id_flush = 1'b1;
      w_ctrl.id_ex_flush = 1'b1;
      w_target           = (r_state == PC_JUMP_PEND) ? r_target : ex_jump_target;
    end else if (r_state == PC_DISCARD) begin
      w_ctrl.if_discard  = 1'b1;
      w_ctrl.if_id_flush = 1'b1;
    end else if (id_stall_req) begin
      // Load-use: hold PC and if_id, inject one bubble into id_ex
      w_ctrl.pc_stall    = 1'b1;
      w_ctrl.if_id_stall = 1'b1;
      w_ctrl.id_ex_flush = 1'b1;
    end else if (if_stall_req) begin
      w_ctrl.pc_stall    = 1'b1;
      w_ctrl.if_id_flush = 1'b1;
    end
  end

  // Sequencer state and parked redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= PC_RUN;
      r_target <= '0;
    end else if (rdy) begin
      case (r_state)
        PC_RUN: begin
          if (ex_jump) begin
            if (mem_stall_req) begin
              r_state  <= PC_JUMP_PEND;
              r_target <= ex_jump_target;
            end else begin
              r_state <= if_stall_req ? PC_DISCARD : PC_RUN;
            end
          end
        end
        PC_JUMP_PEND: begin
          if (!mem_stall_req) begin
            r_state <= if_stall_req ? PC_DISCARD : PC_RUN;
          end
        end
        PC_DISCARD: begin
          if (!if_stall_req) begin
            r_state <= PC_RUN;
          end
        end
        default: begin
          r_state <= PC_RUN;
        end
      endcase
    end
  end

  assign w_stall_inc = w_active && w_ctrl.pc_stall;
  assign w_flush_inc = w_active && w_ctrl.pc_jump;

  // Cycles spent with the PC held
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  // Redirects issued
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );

  assign pc_stall     = w_ctrl.pc_stall;
  assign if_id_stall  = w_ctrl.if_id_stall;
  assign id_ex_stall  = w_ctrl.id_ex_stall;
  assign ex_mem_stall = w_ctrl.ex_mem_stall;
  assign mem_wb_stall = w_ctrl.mem_wb_stall;
  assign if_id_flush  = w_ctrl.if_id_flush;
  assign id_ex_flush  = w_ctrl.id_ex_flush;
  assign if_discard   = w_ctrl.if_discard;
  assign pc_jump      = w_ctrl.pc_jump;
  assign pc_target    = w_target;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic, all
// checked against a rule-level model of the sequencer.
module tb_pipe_ctrl;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst, rdy, if_stall_req, id_stall_req, mem_stall_req, ex_jump;
  logic [ADDR_W-1:0] ex_jump_target;
  logic              pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic              if_id_flush, id_ex_flush, if_discard, pc_jump;
  logic [ADDR_W-1:0] pc_target;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  pipe_ctrl #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .if_stall_req   (if_stall_req),
    .id_stall_req   (id_stall_req),
    .mem_stall_req  (mem_stall_req),
    .ex_jump        (ex_jump),
    .ex_jump_target (ex_jump_target),
    .pc_stall       (pc_stall),
    .if_id_stall    (if_id_stall),
    .id_ex_stall    (id_ex_stall),
    .ex_mem_stall   (ex_mem_stall),
    .mem_wb_stall   (mem_wb_stall),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .if_discard     (if_discard),
    .pc_jump        (pc_jump),
    .pc_target      (pc_target),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Model: a parked redirect (valid + address) and a "drop the fetch" flag
  bit              m_pend;
  logic [ADDR_W-1:0] m_pend_addr;
  bit              m_drop;
  int              m_stalls;
  int              m_flushes;

  // Expected controls as {pc,if_id,id_ex,ex_mem,mem_wb stall, if_id flush, id_ex flush, discard, jump}
  logic [8:0]        e_ctrl;
  logic [ADDR_W-1:0] e_tgt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic predict(input bit r, rd, m, id, f, j, input logic [ADDR_W-1:0] t);
    bit redir;
    e_ctrl = 9'b0;
    e_tgt  = '0;
    redir  = !m && (m_pend || (!m_drop && j));
    if (r)             e_ctrl = 9'b0;
    else if (!rd)      e_ctrl = 9'b1_1111_0000;
    else if (m)        e_ctrl = {5'b11110, 2'b00, m_drop, 1'b0};
    else if (redir) begin
      e_ctrl = 9'b0_0000_1101;
      e_tgt  = m_pend ? m_pend_addr : t;
    end
    else if (m_drop)   e_ctrl = 9'b0_0000_1010;
    else if (id)       e_ctrl = 9'b1_1000_0100;
    else if (f)        e_ctrl = 9'b1_0000_1000;
  endtask

  task automatic advance(input bit r, rd, m, f, j, input logic [ADDR_W-1:0] t);
    bit redir;
    redir = !m && (m_pend || (!m_drop && j));
    if (r) begin
      m_pend = 0; m_pend_addr = '0; m_drop = 0; m_stalls = 0; m_flushes = 0;
    end else if (rd) begin
      if (e_ctrl[8] && m_stalls < CMAX)  m_stalls++;
      if (e_ctrl[0] && m_flushes < CMAX) m_flushes++;
      if (redir) begin
        m_pend = 0;
        m_drop = f;
      end else if (m && j && !m_pend && !m_drop) begin
        m_pend      = 1;
        m_pend_addr = t;
      end else if (m_drop && !f) begin
        m_drop = 0;
      end
    end
  endtask

  // One clock: drive, check mid-cycle, advance the model at the edge
  task automatic step(input string tag, input bit r, rd, m, id, f, j, input logic [ADDR_W-1:0] t);
    rst = r; rdy = rd; mem_stall_req = m; id_stall_req = id; if_stall_req = f;
    ex_jump = j; ex_jump_target = t;
    @(negedge clk);
    predict(r, rd, m, id, f, j, t);
    check({tag, ".ctrl"}, 64'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                              if_id_flush, id_ex_flush, if_discard, pc_jump}), 64'(e_ctrl));
    check({tag, ".tgt"}, 64'(pc_target), 64'(e_tgt));
    check({tag, ".scnt"}, 64'(stall_cnt), 64'(m_stalls));
    check({tag, ".fcnt"}, 64'(flush_cnt), 64'(m_flushes));
    advance(r, rd, m, f, j, t);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 1, 0, 0, 0, 0, '0);
  endtask

  initial begin
    m_pend = 0; m_pend_addr = '0; m_drop = 0; m_stalls = 0; m_flushes = 0;
    rst = 1; rdy = 1; mem_stall_req = 0; id_stall_req = 0; if_stall_req = 0;
    ex_jump = 0; ex_jump_target = '0;
    @(posedge clk); #1;

    // Reset, freeze, idle
    step("rst0", 1, 1, 0, 0, 0, 0, '0);
    step("rst1", 1, 1, 1, 1, 1, 1, 32'h44);
    step("freeze", 0, 0, 1, 1, 1, 0, '0);
    idle("idle");

    // Load-use bubble, then its count
    step("loaduse", 0, 1, 0, 1, 0, 0, '0);
    idle("loaduse_cnt");
    check("loaduse_scnt_is1", 64'(stall_cnt), 64'(1));

    // Jump parked behind a 4-cycle memory stall
    step("mj0", 0, 1, 1, 0, 0, 0, '0);
    step("mj1", 0, 1, 1, 0, 0, 1, 32'h0000_1000);
    step("mj2", 0, 1, 1, 0, 0, 0, 32'hdead_beef);
    step("mj3", 0, 1, 1, 0, 0, 0, '0);
    step("mj_redir", 0, 1, 0, 0, 0, 0, '0);
    idle("mj_after");
    check("mj_fcnt_is1", 64'(flush_cnt), 64'(1));

    // Jump with a fetch in flight: redirect then discard while fetch pending
    step("fj_jump", 0, 1, 0, 0, 1, 1, 32'h80);
    step("fj_d0", 0, 1, 0, 0, 1, 0, '0);
    step("fj_d1", 0, 1, 0, 0, 1, 0, '0);
    step("fj_d2", 0, 1, 0, 0, 0, 0, '0);
    idle("fj_run");

    // All three requests together: redirect only
    step("prio", 0, 1, 0, 1, 1, 1, 32'h200);
    step("prio_d", 0, 1, 0, 0, 0, 0, '0);
    step("id_if", 0, 1, 0, 1, 1, 0, '0);

    // Saturation of the stall counter
    for (int i = 0; i < 20; i++) step("sat", 0, 1, 0, 0, 1, 0, '0);
    idle("sat_end");
    check("sat_scnt_is15", 64'(stall_cnt), 64'(CMAX));

    // Reset while a redirect is parked drops it
    step("rp_park", 0, 1, 1, 0, 0, 1, 32'h300);
    step("rp_rst", 1, 1, 1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) idle("rp_after");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bit r, rd, m, id, f, j;
      r  = ($urandom_range(0, 59) == 0);
      rd = ($urandom_range(0, 7) != 0);
      m  = ($urandom_range(0, 3) == 0);
      id = ($urandom_range(0, 4) == 0);
      f  = ($urandom_range(0, 2) == 0);
      j  = !m_pend && !m_drop && ($urandom_range(0, 4) == 0);
      step("rand", r, rd, m, id, f, j, ADDR_W'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
